// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester round-robin arbiter and sequencer for the
// shared combinational ALU. Each accepted op takes one EXEC cycle to drive
// the ALU and capture its result. The captured result is then returned to
// the granted requester over a valid/ready response channel.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; arbitration and acceptance happen here
//   EXEC  | latched operands drive the ALU; result captured at cycle end
//   RESP  | rsp_valid raised to the granted requester until it accepts
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [2:0]       req_ctrl0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_ctrl1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   sel;

  // Round-robin pick: a lone requester wins outright; under contention the
  // requester that was not served last wins.
  always_comb begin
    sel = 1'b0;
    if (req_valid == 2'b11) begin
      sel = ~last_grant;
    end else if (req_valid[1]) begin
      sel = 1'b1;
    end
  end

  // Accept only in IDLE. Acceptance is also masked while reset is applied,
  // so a requester never sees a handshake that the reset then discards.
  always_comb begin
    req_ready = 2'b00;
    if (!reset && (state == IDLE)) begin
      req_ready[0] = req_valid[0] & ~sel;
      req_ready[1] = req_valid[1] & sel;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            alu_a      <= sel ? req_a1    : req_a0;
            alu_b      <= sel ? req_b1    : req_b0;
            alu_ctrl   <= sel ? req_ctrl1 : req_ctrl0;
            grant_id   <= sel;
            last_grant <= sel;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= grant_id ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          // Only the granted requester's ready bit can end the response.
          if (rsp_ready[grant_id]) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the single shared 32-bit combinational ALU in the pipelined fault-tolerant core. It grants one request at a time using round-robin priority and latches the operands. It then drives the ALU for one execute cycle, registers the result and zero flag, and returns them to the granted requester over a valid/ready response channel. Requester 0 is the pipeline EX stage and requester 1 is the fault-check/recompute unit.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester request accept
- req_a0, req_b0  in  WIDTH  requester 0 operands
- req_ctrl0  in  3  requester 0 alucontrol code
- req_a1, req_b1  in  WIDTH  requester 1 operands
- req_ctrl1  in  3  requester 1 alucontrol code
- rsp_valid  out  2  one-hot response valid to the granted requester
- rsp_ready  in  2  per-requester response accept
- rsp_result  out  WIDTH  registered ALU result
- rsp_zero  out  1  registered ALU zero flag
- alu_a, alu_b  out  WIDTH  registered operands driven to the ALU
- alu_ctrl  out  3  registered alucontrol driven to the ALU
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_ctrl)
- alu_zero  in  1  ALU zero flag
- busy  out  1  high whenever state is not IDLE
- grant_id  out  1  index of the requester being served or last served

## Operation
- ALU codes are passed through unmodified: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl. All 8 codes are legal.
- FSM states and transitions:
  - IDLE -> EXEC on any accepted request.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE when rsp_valid[grant_id] && rsp_ready[grant_id].
- Arbitration is evaluated in IDLE only:
  - Only one req_valid bit high: that requester is selected.
  - Both bits high: the requester != last_grant is selected.
  - req_ready[i] = (state==IDLE) && req_valid[i] && selected==i. req_ready is never high outside IDLE and never for both bits.
- On acceptance: alu_a/alu_b/alu_ctrl <= the selected requester's operands, grant_id <= i, last_grant <= i.
- EXEC: rsp_result <= alu_result and rsp_zero <= alu_zero at the end of the cycle.
- RESP: rsp_valid[grant_id]=1, other bit 0. rsp_result and rsp_zero are held stable until the handshake completes.
- alu_a/alu_b/alu_ctrl hold their value until the next acceptance.
- A requester must hold req_valid and its operands stable until accepted. The block never drops or reorders an accepted request.
- Reset values: state IDLE; req_ready 0; rsp_valid 0; rsp_result 0; rsp_zero 0; alu_a/alu_b/alu_ctrl 0; busy 0; grant_id 0; last_grant 1, so requester 0 wins the first contention.
- Reset in EXEC or RESP discards the in-flight op: no response is issued and all registers return to reset values.

## Timing
- Cycle 0 (IDLE, handshake) -> cycle 1 (EXEC) -> cycle 2 (RESP, rsp_valid high).
- Accept-to-rsp_valid latency is 2 cycles.
- With rsp_ready held high, the next request can be accepted in cycle 3. Peak throughput is 1 op per 3 cycles.
- Backpressure: RESP is held indefinitely while rsp_ready[grant_id]=0. No new request is accepted during that time.
- rsp_ready on the non-granted bit is ignored.
- req_ready is combinational from req_valid and state. All other outputs are registered.

## Test plan
- Reset: assert reset for 2 cycles with req_valid=11 -> all outputs 0, busy 0, and no acceptance while reset is high.
- Single op: req0 a=0x5, b=0x3, ctrl=000 -> req_ready[0] in the valid cycle; 2 cycles later rsp_valid=01, rsp_result=0x8, rsp_zero=0.
- Contention:
  - Stimulus: both valid; req0 8-3 (001), req1 0xFFFFFFFF & 0x0F0F0F0F (010); both stay valid with new ops afterward.
  - Required response: req0 served first (0x5), then req1 (0x0F0F0F0F); grants keep alternating 0,1,0,1.
- Backpressure and zero flag:
  - Stimulus: req1 a=0x2, b=0x2, ctrl=001, rsp_ready=00 for 5 cycles while req0 is valid.
  - Required response: rsp_valid=10, rsp_result=0, rsp_zero=1, all held stable; req_ready=00 throughout. req0 is accepted in the cycle after rsp_ready[1] rises.
- Reset mid-op: accept req0 0xAAAAAAAA | 0x55555555, then assert reset during EXEC -> next cycle IDLE, rsp_valid never rises, rsp_result=0.
- Throughput and shifts:
  - Stimulus: req0 continuously valid with rsp_ready=11, issuing sll 0x1,0x4 then srl 0x10,0x2.
  - Required response: acceptances exactly 3 cycles apart; results 0x10 then 0x4.
